// File: rtl/controller_pkg.sv
// Shared opcodes, FSM state encoding and instruction field layout for loop-controller instruction consumers.
// Latency: none, declarations only.
// Backpressure: not applicable.
package controller_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LOOP_CFG  = 4'h1;
    localparam logic [OPC_W-1:0] OP_BLOCK_END = 4'h2;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RETIRE = 2'd3
    } state_t;

    // Field layout: opcode in the top nibble, group directly above the trip count.
    function automatic int opc_lsb(input int inst_w);
        return inst_w - OPC_W;
    endfunction

    function automatic int grp_lsb(input int loop_iter_w);
        return loop_iter_w;
    endfunction

    localparam int TRIP_LSB = 0;

endpackage

// File: rtl/loop_cfg_decode.sv
// Combinational decode of loop instruction fields into class flags and a trip-minus-one value.
// Latency: 0 cycles.
// Backpressure: none, pure function of its inputs.
module loop_cfg_decode
    import controller_pkg::*;
#(
    parameter int GROUP_ID_W  = 2,
    parameter int LOOP_ITER_W = 16
) (
    input  logic [OPC_W-1:0]       opcode,
    input  logic [GROUP_ID_W-1:0]  group,
    input  logic [LOOP_ITER_W-1:0] trip,
    output logic                   is_cfg,
    output logic                   is_end,
    output logic                   is_illegal,
    output logic                   is_zero,
    output logic [LOOP_ITER_W-1:0] trip_m1,
    output logic [GROUP_ID_W-1:0]  group_id
);

    assign is_cfg     = (opcode == OP_LOOP_CFG);
    assign is_end     = (opcode == OP_BLOCK_END);
    assign is_illegal = !(is_cfg || is_end);
    assign is_zero    = (trip == '0);
    // A zero trip count is reported as a single iteration rather than wrapping.
    assign trip_m1    = is_zero ? '0 : trip - LOOP_ITER_W'(1);
    assign group_id   = group;

endmodule

// File: rtl/controller_loop_cfg_issuer.sv
// Decodes loop instructions, assigns per-group loop ids and sequences start/done/retire with the loop controller.
// Latency: 1 cycle accept-to-strobe, accept-to-start, done-to-retire and retire-to-next-accept.
// Backpressure: inst_ready is high only in IDLE; instructions stall for the whole START/RUN/RETIRE span.
module controller_loop_cfg_issuer
    import controller_pkg::*;
#(
    parameter int LOOP_ID_W   = 5,
    parameter int GROUP_ID_W  = 2,
    parameter int LOOP_ITER_W = 16,
    parameter int INST_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inst_v,
    input  logic [INST_W-1:0]      inst,
    output logic                   inst_ready,
    input  logic                   ctrl_done,
    output logic                   cfg_loop_iter_v,
    output logic [LOOP_ITER_W-1:0] cfg_loop_iter,
    output logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
    output logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
    output logic                   start,
    output logic                   has_start,
    output logic                   block_done,
    output logic                   busy,
    output logic                   err_op,
    output logic                   err_ovf,
    output logic                   err_zero,
    input  logic                   err_clr
);

    localparam int NUM_MAX_LOOPS  = 1 << LOOP_ID_W;
    localparam int NUM_MAX_GROUPS = 1 << GROUP_ID_W;
    localparam int OPC_LSB        = opc_lsb(INST_W);
    localparam int GRP_LSB        = grp_lsb(LOOP_ITER_W);
    localparam int RSVD_W         = OPC_LSB - (GRP_LSB + GROUP_ID_W);
    localparam logic [LOOP_ID_W:0] CNT_FULL = (LOOP_ID_W + 1)'(NUM_MAX_LOOPS);

    state_t state, state_nxt;

    logic [OPC_W-1:0]       opcode;
    logic [GROUP_ID_W-1:0]  grp_fld;
    logic [LOOP_ITER_W-1:0] trip_fld;

    logic                   is_cfg, is_end, is_illegal, is_zero;
    logic [LOOP_ITER_W-1:0] trip_m1;
    logic [GROUP_ID_W-1:0]  group_id;

    // One spare bit so a full group is distinguishable from an empty one.
    logic [LOOP_ID_W:0]     cnt [NUM_MAX_GROUPS];
    logic [LOOP_ID_W:0]     grp_cnt;
    logic                   grp_full;
    logic                   acc;
    logic                   cfg_ok;

    assign opcode   = inst[OPC_LSB +: OPC_W];
    assign grp_fld  = inst[GRP_LSB +: GROUP_ID_W];
    assign trip_fld = inst[TRIP_LSB +: LOOP_ITER_W];

    generate
        if (RSVD_W > 0) begin : g_rsvd
            logic unused_rsvd;
            assign unused_rsvd = ^inst[GRP_LSB + GROUP_ID_W +: RSVD_W];
        end
    endgenerate

    loop_cfg_decode #(
        .GROUP_ID_W  (GROUP_ID_W),
        .LOOP_ITER_W (LOOP_ITER_W)
    ) u_decode (
        .opcode     (opcode),
        .group      (grp_fld),
        .trip       (trip_fld),
        .is_cfg     (is_cfg),
        .is_end     (is_end),
        .is_illegal (is_illegal),
        .is_zero    (is_zero),
        .trip_m1    (trip_m1),
        .group_id   (group_id)
    );

    assign grp_cnt  = cnt[group_id];
    assign grp_full = (grp_cnt == CNT_FULL);
    assign acc      = inst_v && inst_ready;
    assign cfg_ok   = acc && is_cfg && !grp_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        inst_ready = 1'b0;
        busy       = 1'b1;
        start      = 1'b0;
        has_start  = 1'b0;
        block_done = 1'b0;
        case (state)
            ST_IDLE: begin
                inst_ready = 1'b1;
                busy       = 1'b0;
                if (inst_v && is_end) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                start     = 1'b1;
                has_start = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                has_start = 1'b1;
                if (ctrl_done) begin
                    state_nxt = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                has_start  = 1'b1;
                block_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_loop_iter_v       <= 1'b0;
            cfg_loop_iter         <= '0;
            cfg_loop_iter_loop_id <= '0;
            cfg_loop_group_id     <= '0;
        end else begin
            cfg_loop_iter_v <= cfg_ok;
            if (cfg_ok) begin
                cfg_loop_iter         <= trip_m1;
                cfg_loop_iter_loop_id <= grp_cnt[LOOP_ID_W-1:0];
                cfg_loop_group_id     <= group_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
                cnt[g] <= '0;
            end
        end else if (state == ST_RETIRE) begin
            for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
                cnt[g] <= '0;
            end
        end else if (cfg_ok) begin
            cnt[group_id] <= grp_cnt + (LOOP_ID_W + 1)'(1);
        end
    end

    // Clear wins over a same-cycle set; block retire leaves the sticky bits alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_op   <= 1'b0;
            err_ovf  <= 1'b0;
            err_zero <= 1'b0;
        end else if (err_clr) begin
            err_op   <= 1'b0;
            err_ovf  <= 1'b0;
            err_zero <= 1'b0;
        end else begin
            if (acc && is_illegal)          err_op   <= 1'b1;
            if (acc && is_cfg && grp_full)  err_ovf  <= 1'b1;
            if (cfg_ok && is_zero)          err_zero <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controller_loop_cfg_issuer.sv
// Randomized and directed checks of the loop config issuer against a queue-free behavioural model.
module tb_controller_loop_cfg_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_v;
    logic [31:0] inst;
    logic        inst_ready;
    logic        ctrl_done;
    logic        cfg_loop_iter_v;
    logic [15:0] cfg_loop_iter;
    logic [4:0]  cfg_loop_iter_loop_id;
    logic [1:0]  cfg_loop_group_id;
    logic        start, has_start, block_done, busy;
    logic        err_op, err_ovf, err_zero, err_clr;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          m_cnt [4];
    logic [15:0] m_iter;
    logic [4:0]  m_id;
    logic [1:0]  m_grp;
    logic        m_eop, m_eovf, m_ezero;

    always #5 clk = ~clk;

    controller_loop_cfg_issuer dut (
        .clk                   (clk),
        .reset                 (reset),
        .inst_v                (inst_v),
        .inst                  (inst),
        .inst_ready            (inst_ready),
        .ctrl_done             (ctrl_done),
        .cfg_loop_iter_v       (cfg_loop_iter_v),
        .cfg_loop_iter         (cfg_loop_iter),
        .cfg_loop_iter_loop_id (cfg_loop_iter_loop_id),
        .cfg_loop_group_id     (cfg_loop_group_id),
        .start                 (start),
        .has_start             (has_start),
        .block_done            (block_done),
        .busy                  (busy),
        .err_op                (err_op),
        .err_ovf               (err_ovf),
        .err_zero              (err_zero),
        .err_clr               (err_clr)
    );

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [1:0] g, input logic [15:0] t);
        return {op, 10'b0, g, t};
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 4; g++) m_cnt[g] = 0;
        m_iter = '0; m_id = '0; m_grp = '0;
        m_eop = 1'b0; m_eovf = 1'b0; m_ezero = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        inst   = w;
        inst_v = 1'b1;
        while (!inst_ready && n < 50) begin
            step();
            n++;
        end
        tests++;
        if (inst_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_timeout: inst_ready=%0b required 1", inst_ready);
        end
        step();
        inst_v = 1'b0;
    endtask

    // Any non-BLOCK_END instruction, with the model's expected strobe and error state.
    task automatic do_inst(input logic [31:0] w, input string tag);
        logic [3:0]  op = w[31:28];
        logic [1:0]  g  = w[17:16];
        logic [15:0] t  = w[15:0];
        logic        exp_v = 1'b0;
        if (op == 4'h1) begin
            if (m_cnt[g] == 32) begin
                m_eovf = 1'b1;
            end else begin
                exp_v  = 1'b1;
                m_iter = (t == 0) ? 16'd0 : t - 16'd1;
                m_id   = 5'(m_cnt[g]);
                m_grp  = g;
                m_cnt[g]++;
                if (t == 0) m_ezero = 1'b1;
            end
        end else begin
            m_eop = 1'b1;
        end
        send(w);
        tests++;
        if (cfg_loop_iter_v !== exp_v || cfg_loop_iter !== m_iter ||
            cfg_loop_iter_loop_id !== m_id || cfg_loop_group_id !== m_grp) begin
            fails++;
            $display("FAIL %s strobe: got v=%0b it=%0d id=%0d g=%0d, want v=%0b it=%0d id=%0d g=%0d",
                     tag, cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, cfg_loop_group_id,
                     exp_v, m_iter, m_id, m_grp);
        end
        tests++;
        if ({err_op, err_ovf, err_zero} !== {m_eop, m_eovf, m_ezero}) begin
            fails++;
            $display("FAIL %s errors: got op/ovf/zero=%b want %b", tag,
                     {err_op, err_ovf, err_zero}, {m_eop, m_eovf, m_ezero});
        end
    endtask

    task automatic run_block(input int dly);
        send(mk(4'h2, 2'd0, 16'd0));
        tests++;
        if ({start, has_start, busy, inst_ready, cfg_loop_iter_v} !== 5'b11100) begin
            fails++;
            $display("FAIL start_pulse: got start/has/busy/rdy/v=%b want 11100",
                     {start, has_start, busy, inst_ready, cfg_loop_iter_v});
        end
        step();
        tests++;
        if ({start, has_start, busy, block_done} !== 4'b0110) begin
            fails++;
            $display("FAIL run_enter: got start/has/busy/done=%b want 0110",
                     {start, has_start, busy, block_done});
        end
        for (int i = 0; i < dly; i++) step();
        tests++;
        if (block_done !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL run_wait: got done=%0b busy=%0b want 0 1", block_done, busy);
        end
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        tests++;
        if ({block_done, inst_ready, busy} !== 3'b101) begin
            fails++;
            $display("FAIL retire: got done/rdy/busy=%b want 101", {block_done, inst_ready, busy});
        end
        step();
        tests++;
        if ({block_done, inst_ready, busy, has_start, start} !== 5'b01000) begin
            fails++;
            $display("FAIL idle_after: got done/rdy/busy/has/start=%b want 01000",
                     {block_done, inst_ready, busy, has_start, start});
        end
        for (int g = 0; g < 4; g++) m_cnt[g] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0; inst_v = 1'b0; inst = '0; ctrl_done = 1'b0; err_clr = 1'b0;
        model_reset();
        step(); step();
        tests++;
        if ({cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, cfg_loop_group_id,
             start, has_start, block_done, busy, err_op, err_ovf, err_zero} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: some output nonzero during reset (v=%0b start=%0b busy=%0b)",
                     cfg_loop_iter_v, start, busy);
        end
        reset = 1'b1;
        step();
        tests++;
        if (inst_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got rdy=%0b busy=%0b want 1 0", inst_ready, busy);
        end
    endtask

    task automatic test_basic();
        do_inst(mk(4'h1, 2'd0, 16'd4), "basic_cfg0");
        do_inst(mk(4'h1, 2'd0, 16'd3), "basic_cfg1");
        run_block(5);
    endtask

    task automatic test_interleave();
        do_inst(mk(4'h1, 2'd1, 16'd2), "il_g1a");
        do_inst(mk(4'h1, 2'd0, 16'd5), "il_g0");
        do_inst(mk(4'h1, 2'd1, 16'd7), "il_g1b");
        tests++;
        if (cfg_loop_iter_loop_id !== 5'd1 || cfg_loop_iter !== 16'd6) begin
            fails++;
            $display("FAIL il_second_g1: got id=%0d it=%0d want 1 6", cfg_loop_iter_loop_id, cfg_loop_iter);
        end
        run_block(2);
        do_inst(mk(4'h1, 2'd1, 16'd9), "il_after_retire");
        run_block(0);
    endtask

    task automatic test_backpressure();
        send(mk(4'h2, 2'd0, 16'd0));
        step();
        inst   = mk(4'h1, 2'd3, 16'd9);
        inst_v = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (inst_ready !== 1'b0 || cfg_loop_iter_v !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall: got rdy=%0b v=%0b want 0 0", inst_ready, cfg_loop_iter_v);
            end
            step();
        end
        ctrl_done = 1'b1;
        step();
        ctrl_done = 1'b0;
        tests++;
        if ({block_done, inst_ready, cfg_loop_iter_v} !== 3'b100) begin
            fails++;
            $display("FAIL bp_retire: got done/rdy/v=%b want 100", {block_done, inst_ready, cfg_loop_iter_v});
        end
        step();
        tests++;
        if ({inst_ready, cfg_loop_iter_v} !== 2'b10) begin
            fails++;
            $display("FAIL bp_reopen: got rdy/v=%b want 10", {inst_ready, cfg_loop_iter_v});
        end
        step();
        inst_v = 1'b0;
        for (int g = 0; g < 4; g++) m_cnt[g] = 0;
        m_cnt[3] = 1; m_iter = 16'd8; m_id = 5'd0; m_grp = 2'd3;
        tests++;
        if (cfg_loop_iter_v !== 1'b1 || cfg_loop_iter !== 16'd8 ||
            cfg_loop_iter_loop_id !== 5'd0 || cfg_loop_group_id !== 2'd3) begin
            fails++;
            $display("FAIL bp_accept: got v=%0b it=%0d id=%0d g=%0d want 1 8 0 3",
                     cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, cfg_loop_group_id);
        end
        run_block(1);
    endtask

    task automatic test_errors();
        int strobes = 0;
        do_inst(mk(4'hF, 2'd0, 16'd5), "err_op");
        do_inst(mk(4'h1, 2'd1, 16'd0), "err_zero");
        for (int i = 0; i < 33; i++) begin
            do_inst(mk(4'h1, 2'd2, 16'($urandom_range(1, 1000))), "err_ovf_fill");
            strobes += int'(cfg_loop_iter_v);
        end
        tests++;
        if (strobes != 32 || err_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_count: got strobes=%0d ovf=%0b want 32 1", strobes, err_ovf);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_eop = 1'b0; m_eovf = 1'b0; m_ezero = 1'b0;
        tests++;
        if ({err_op, err_ovf, err_zero} !== 3'b000) begin
            fails++;
            $display("FAIL err_clr: got %b want 000", {err_op, err_ovf, err_zero});
        end
        // Clear coincident with an illegal opcode must leave the bit clear.
        err_clr = 1'b1;
        send(mk(4'h7, 2'd0, 16'd1));
        err_clr = 1'b0;
        tests++;
        if (err_op !== 1'b0) begin
            fails++;
            $display("FAIL err_clr_prio: got err_op=%0b want 0", err_op);
        end
        run_block(3);
        tests++;
        if (err_op !== m_eop || err_ovf !== m_eovf) begin
            fails++;
            $display("FAIL err_after_retire: got op=%0b ovf=%0b want %0b %0b", err_op, err_ovf, m_eop, m_eovf);
        end
    endtask

    task automatic test_edges();
        run_block(0);
        ctrl_done = 1'b1;
        step(); step();
        ctrl_done = 1'b0;
        tests++;
        if (block_done !== 1'b0 || busy !== 1'b0 || inst_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_done_ignored: got done=%0b busy=%0b rdy=%0b want 0 0 1",
                     block_done, busy, inst_ready);
        end
        do_inst(mk(4'h1, 2'd0, 16'd12), "edge_after_idle_done");
        step();
        tests++;
        if (cfg_loop_iter_v !== 1'b0 || cfg_loop_iter !== m_iter || cfg_loop_iter_loop_id !== m_id) begin
            fails++;
            $display("FAIL strobe_hold: got v=%0b it=%0d id=%0d want 0 %0d %0d",
                     cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, m_iter, m_id);
        end
        run_block(4);
    endtask

    task automatic test_random();
        for (int n = 0; n < 250; n++) begin
            int r = $urandom_range(0, 19);
            if (r == 0) begin
                logic [3:0] op = 4'($urandom_range(3, 15));
                do_inst(mk(op, 2'($urandom), 16'($urandom)), "rnd_illegal");
            end else if (r <= 2) begin
                run_block($urandom_range(0, 6));
            end else if (r == 3) begin
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                m_eop = 1'b0; m_eovf = 1'b0; m_ezero = 1'b0;
                tests++;
                if ({err_op, err_ovf, err_zero} !== 3'b000) begin
                    fails++;
                    $display("FAIL rnd_clr: got %b want 000", {err_op, err_ovf, err_zero});
                end
            end else begin
                logic [15:0] t = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
                do_inst(mk(4'h1, 2'($urandom), t), "rnd_cfg");
            end
        end
        run_block(1);
    endtask

    task automatic test_reset_mid_run();
        do_inst(mk(4'h1, 2'd1, 16'd20), "rmr_cfg");
        do_inst(mk(4'h3, 2'd0, 16'd0), "rmr_illegal");
        send(mk(4'h2, 2'd0, 16'd0));
        step();
        reset = 1'b0;
        #1;
        tests++;
        if ({cfg_loop_iter_v, cfg_loop_iter, cfg_loop_iter_loop_id, cfg_loop_group_id,
             start, has_start, block_done, busy, err_op, err_ovf, err_zero} !== '0) begin
            fails++;
            $display("FAIL rmr_outputs: nonzero after reset (it=%0d has=%0b busy=%0b op=%0b)",
                     cfg_loop_iter, has_start, busy, err_op);
        end
        ctrl_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (block_done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL rmr_no_done: got done=%0b busy=%0b want 0 0", block_done, busy);
            end
        end
        ctrl_done = 1'b0;
        reset = 1'b1;
        model_reset();
        step();
        tests++;
        if (inst_ready !== 1'b1 || block_done !== 1'b0) begin
            fails++;
            $display("FAIL rmr_release: got rdy=%0b done=%0b want 1 0", inst_ready, block_done);
        end
        do_inst(mk(4'h1, 2'd1, 16'd6), "rmr_next_cfg");
        run_block(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_backpressure();
        test_errors();
        test_edges();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controller_loop_cfg_issuer.md
Name: controller_loop_cfg_issuer

Overview:
Transmit side of the loop-configuration interface. Accepts a stream of packed loop instructions over a valid/ready handshake and decodes them. Drives a loop controller's cfg_loop_iter_v / cfg_loop_iter / cfg_loop_iter_loop_id / cfg_loop_group_id pins, its start / has_start handshake and block_done. Per block, it assigns loop ids in order, issues start, waits for the controller's done, then retires the block.

Parameters:
LOOP_ID_W, 5, loop id width; NUM_MAX_LOOPS = 1 << LOOP_ID_W
GROUP_ID_W, 2, group id width; NUM_MAX_GROUPS = 1 << GROUP_ID_W
LOOP_ITER_W, 16, iteration field width
INST_W, 32, instruction word width; must be >= 4 + GROUP_ID_W + LOOP_ITER_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
inst_v  in  1  instruction valid
inst  in  INST_W  instruction word
inst_ready  out  1  issuer can accept inst this cycle
ctrl_done  in  1  done from the loop controller
cfg_loop_iter_v  out  1  loop config strobe
cfg_loop_iter  out  LOOP_ITER_W  max iteration index (trip count - 1)
cfg_loop_iter_loop_id  out  LOOP_ID_W  loop id assigned by issuer
cfg_loop_group_id  out  GROUP_ID_W  group of this loop
start  out  1  one-cycle block start pulse
has_start  out  1  high from start pulse until block retire
block_done  out  1  one-cycle block retire pulse
busy  out  1  state != IDLE
err_op  out  1  sticky: illegal opcode seen
err_ovf  out  1  sticky: more than NUM_MAX_LOOPS loops in a group
err_zero  out  1  sticky: trip count 0 seen
err_clr  in  1  clears the three sticky error bits

Behaviour:
- Instruction format: [INST_W-1 -: 4] opcode; [LOOP_ITER_W +: GROUP_ID_W] group; [LOOP_ITER_W-1:0] trip count.
- Opcodes: 4'h1 LOOP_CFG; 4'h2 BLOCK_END. All others are illegal.
- Transfer occurs when inst_v && inst_ready.
- States: IDLE, START, RUN, RETIRE.
- IDLE: inst_ready=1.
  - LOOP_CFG accepted: one cycle later, cfg_loop_iter_v=1 with cfg_loop_iter = trip-1, cfg_loop_iter_loop_id = cnt[group], cfg_loop_group_id = group. Then cnt[group]++.
  - Trip count 0: send 0 and set err_zero.
  - cnt[group] == NUM_MAX_LOOPS (already full): drop the instruction, no strobe, set err_ovf. Counter saturates and does not wrap.
  - Illegal opcode: dropped, err_op set, stays IDLE.
  - BLOCK_END accepted: go to START. A block with zero configured loops is legal.
- START: inst_ready=0. start=1 for exactly one cycle, has_start is set, then go to RUN.
- RUN: inst_ready=0. Wait for ctrl_done.
  - ctrl_done is sampled only in RUN and ignored in every other state.
  - ctrl_done on the first RUN cycle is honoured.
- RETIRE: block_done=1 for one cycle. has_start clears, all cnt[] clear, return to IDLE. inst_ready stays 0 in this cycle.
- Latency:
  - LOOP_CFG accept to strobe: 1 cycle.
  - BLOCK_END accept to start pulse: 1 cycle.
  - ctrl_done to block_done: 1 cycle.
  - block_done to next accept: 1 cycle.
- cfg strobe outputs are registered. cfg_loop_iter/id/group hold their last value when the strobe is low.
- Error bits:
  - err_clr has priority over a same-cycle set, so the bit is cleared.
  - Error bits are not cleared by block retire.
- Reset (any time, including mid-RUN): state=IDLE, cnt[]=0, all outputs 0 except inst_ready, which is 1 after reset deasserts. Error bits are 0. No block_done is emitted for the aborted block.

Decomposition:
- Shared package controller_pkg holds:
  - opcode localparams OP_LOOP_CFG=4'h1, OP_BLOCK_END=4'h2;
  - state encoding (IDLE=0, START=1, RUN=2, RETIRE=3, STATE_W=2);
  - instruction field offsets.
- One natural sub-module: loop_cfg_decode. It is purely combinational: it takes the opcode/group/trip fields and produces is_cfg, is_end, is_illegal, trip_m1 and is_zero. It is reused by other instruction consumers.
- Per-group counters and the FSM stay in the top module.

Test Plan:
- Config and run: LOOP_CFG g0 trips 4, 3, then BLOCK_END.
  - Strobes: (iter 3, id 0, grp 0) then (iter 2, id 1, grp 0).
  - start pulses once, has_start=1.
  - ctrl_done at cycle +5 gives block_done 1 cycle later, busy=0, inst_ready=1.
- Interleaved groups: cfg g1 trip 2, g0 trip 5, g1 trip 7.
  - Resulting ids: g1 -> 0, g0 -> 0, g1 -> 1.
  - After retire, a new g1 cfg gets id 0.
- Backpressure: hold inst_v with LOOP_CFG during RUN.
  - inst_ready=0 and no strobe until the cycle after block_done.
  - Then the instruction is accepted and gets id 0.
- Errors:
  - opcode 4'hF: no strobe, err_op=1.
  - trip 0: strobe with iter 0, err_zero=1.
  - 33 cfgs to g2 with LOOP_ID_W=5: 32 strobes, err_ovf=1.
  - err_clr clears all three error bits.
- Edge cases:
  - BLOCK_END with no loops: start issued, then ctrl_done gives block_done.
  - ctrl_done pulsed in IDLE: ignored, no block_done.
- Reset mid-RUN (reset=0 for 2 cycles): all outputs 0, no block_done. After release, inst_ready=1 and the next cfg gets id 0.
